// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB first on w,
// Repeat+1 times with GAP idle cycles between frames, and reports progress flags.
module serial_pattern_tx #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4,
    parameter int unsigned GAP   = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Pattern,
    input  logic [CNT_W-1:0] Repeat,
    input  logic             Abort,
    output logic             w,
    output logic             Valid,
    output logic             FrameEnd,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned BIT_W = $clog2(WIDTH);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   latch_q, latch_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   rep_q, rep_d;
    logic               valid_q, valid_d;
    logic               fe_q, fe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // The shift register MSB is the w flop itself; it is zeroed whenever no bit is on the line.
    assign w        = shift_q[WIDTH-1];
    assign Valid    = valid_q;
    assign FrameEnd = fe_q;
    assign Busy     = busy_q;
    assign Done     = done_q;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            latch_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            rep_q   <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            latch_q <= latch_d;
            bit_q   <= bit_d;
            gap_q   <= gap_d;
            rep_q   <= rep_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state and the values every output flop takes in the following cycle.
    always_comb begin
        state_d = state_q;
        shift_d = '0;
        latch_d = latch_q;
        bit_d   = bit_q;
        gap_d   = gap_q;
        rep_d   = rep_q;
        valid_d = 1'b0;
        fe_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    state_d = S_SEND;
                    shift_d = Pattern;
                    latch_d = Pattern;
                    rep_d   = Repeat;
                    bit_d   = BIT_W'(WIDTH - 1);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_SEND: begin
                if (Abort) begin
                    state_d = S_IDLE;
                    bit_d   = '0;
                    gap_d   = '0;
                    rep_d   = '0;
                end else if (bit_q != '0) begin
                    shift_d = {shift_q[WIDTH-2:0], 1'b0};
                    bit_d   = bit_q - BIT_W'(1);
                    fe_d    = (bit_q == BIT_W'(1));
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q != '0) begin
                    rep_d = rep_q - CNT_W'(1);
                    if (GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_W'(GAP - 1);
                        busy_d  = 1'b1;
                    end else begin
                        shift_d = latch_q;
                        bit_d   = BIT_W'(WIDTH - 1);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                    end
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (Abort) begin
                    state_d = S_IDLE;
                    bit_d   = '0;
                    gap_d   = '0;
                    rep_d   = '0;
                end else if (gap_q != '0) begin
                    gap_d  = gap_q - GAP_W'(1);
                    busy_d = 1'b1;
                end else begin
                    state_d = S_SEND;
                    shift_d = latch_q;
                    bit_d   = BIT_W'(WIDTH - 1);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a GAP=2 and a GAP=0 instance share stimulus and are
// checked cycle by cycle against frame-level expected streams.
module tb_serial_pattern_tx;

    typedef logic [4:0] vec_t;   // {w, Valid, FrameEnd, Busy, Done}
    typedef vec_t vec_q_t[$];

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Abort = 1'b0;
    logic [3:0] Pattern = 4'b0;
    logic [3:0] Repeat = 4'b0;
    logic       w2, v2, fe2, b2, d2;
    logic       w0, v0, fe0, b0, d0;

    int total = 0;
    int bad   = 0;

    serial_pattern_tx #(.WIDTH(4), .CNT_W(4), .GAP(2)) dut_gap2 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Pattern(Pattern), .Repeat(Repeat),
        .Abort(Abort), .w(w2), .Valid(v2), .FrameEnd(fe2), .Busy(b2), .Done(d2)
    );

    serial_pattern_tx #(.WIDTH(4), .CNT_W(4), .GAP(0)) dut_gap0 (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Pattern(Pattern), .Repeat(Repeat),
        .Abort(Abort), .w(w0), .Valid(v0), .FrameEnd(fe0), .Busy(b0), .Done(d0)
    );

    always #5 Clock = ~Clock;

    // Expected stream from the first bit cycle: frames, gaps between frames, one Done cycle.
    function automatic vec_q_t build(input logic [3:0] pat, input int rep, input int gap);
        vec_q_t q;
        for (int f = 0; f <= rep; f++) begin
            for (int b = 3; b >= 0; b--)
                q.push_back({pat[b], 1'b1, 1'(b == 0), 1'b1, 1'b0});
            if (f < rep)
                for (int g = 0; g < gap; g++) q.push_back(5'b00010);
        end
        q.push_back(5'b00001);
        return q;
    endfunction

    // An Abort seen while busy ends the stream: everything after that cycle is idle.
    function automatic vec_q_t cut(input vec_q_t q, input int j);
        if (j >= 0 && j < q.size() && q[j][1])
            while (q.size() > j + 1) void'(q.pop_back());
        return q;
    endfunction

    function automatic vec_t at(input vec_q_t q, input int c);
        return (c < q.size()) ? q[c] : 5'b00000;
    endfunction

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b1; Abort = 1'b1; Pattern = 4'b1111; Repeat = 4'd0;
        @(posedge Clock); @(posedge Clock); #1;
        total += 2;
        if ({w2, v2, fe2, b2, d2} !== 5'b00000) begin
            bad++; $display("FAIL reset gap2: got %b want %b", {w2, v2, fe2, b2, d2}, 5'b00000);
        end
        if ({w0, v0, fe0, b0, d0} !== 5'b00000) begin
            bad++; $display("FAIL reset gap0: got %b want %b", {w0, v0, fe0, b0, d0}, 5'b00000);
        end
        Reset = 1'b0; Start = 1'b0; Abort = 1'b0;
        @(posedge Clock); #1;
        total += 2;
        if ({w2, v2, fe2, b2, d2} !== 5'b00000) begin
            bad++; $display("FAIL reset_idle gap2: got %b want %b", {w2, v2, fe2, b2, d2}, 5'b00000);
        end
        if ({w0, v0, fe0, b0, d0} !== 5'b00000) begin
            bad++; $display("FAIL reset_idle gap0: got %b want %b", {w0, v0, fe0, b0, d0}, 5'b00000);
        end
    endtask

    // Runs one transmission; j = cycle Abort is held (-1 none), m = cycle of a stray Start (-1 none).
    task automatic test_stream(input logic [3:0] pat, input logic [3:0] rep, input int j,
                               input int m, input string name);
        vec_q_t e2, e0;
        int     n;
        e2 = cut(build(pat, int'(rep), 2), j);
        e0 = cut(build(pat, int'(rep), 0), j);
        n  = build(pat, int'(rep), 2).size() + 2;
        Pattern = pat; Repeat = rep; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0; Pattern = 4'($urandom); Repeat = 4'($urandom);
        for (int c = 0; c < n; c++) begin
            total += 2;
            if ({w2, v2, fe2, b2, d2} !== at(e2, c)) begin
                bad++;
                $display("FAIL %s gap2 cycle %0d: got %b want %b", name, c, {w2, v2, fe2, b2, d2}, at(e2, c));
            end
            if ({w0, v0, fe0, b0, d0} !== at(e0, c)) begin
                bad++;
                $display("FAIL %s gap0 cycle %0d: got %b want %b", name, c, {w0, v0, fe0, b0, d0}, at(e0, c));
            end
            Abort = (c == j);
            Start = (c == m);
            if (c == m) begin
                Pattern = 4'($urandom); Repeat = 4'($urandom);
            end
            @(posedge Clock); #1;
        end
        Abort = 1'b0; Start = 1'b0;
    endtask

    task automatic test_single();       test_stream(4'b1001, 4'd0, -1, -1, "single");     endtask
    task automatic test_repeat_gap();   test_stream(4'b1111, 4'd1, -1, -1, "repeat_gap"); endtask
    task automatic test_back_to_back(); test_stream(4'b1010, 4'd2, -1, -1, "back2back");  endtask
    task automatic test_start_ignored(); test_stream(4'b0110, 4'd2, -1, 3, "start_ign");  endtask

    task automatic test_abort();
        // index 7 on the GAP=2 stream is the 2nd bit of frame 2
        test_stream(4'b1100, 4'd3, 7, -1, "abort");
        test_stream(4'b1011, 4'd1, -1, -1, "after_abort");
    endtask

    task automatic test_reset_mid();
        vec_q_t q;
        Pattern = 4'b0110; Repeat = 4'd2; Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        total += 2;
        if ({w2, v2, fe2, b2, d2} !== 5'b11010) begin
            bad++; $display("FAIL rst_mid_bit3 gap2: got %b want %b", {w2, v2, fe2, b2, d2}, 5'b11010);
        end
        if ({w0, v0, fe0, b0, d0} !== 5'b11010) begin
            bad++; $display("FAIL rst_mid_bit3 gap0: got %b want %b", {w0, v0, fe0, b0, d0}, 5'b11010);
        end
        Reset = 1'b1; Abort = 1'b1; Start = 1'b1;
        @(posedge Clock); #1;
        total += 2;
        if ({w2, v2, fe2, b2, d2} !== 5'b00000) begin
            bad++; $display("FAIL rst_mid gap2: got %b want %b", {w2, v2, fe2, b2, d2}, 5'b00000);
        end
        if ({w0, v0, fe0, b0, d0} !== 5'b00000) begin
            bad++; $display("FAIL rst_mid gap0: got %b want %b", {w0, v0, fe0, b0, d0}, 5'b00000);
        end
        Reset = 1'b0; Abort = 1'b0; Start = 1'b1; Pattern = 4'b1011; Repeat = 4'd0;
        q = build(4'b1011, 0, 2);
        @(posedge Clock); #1;
        Start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            total += 2;
            if ({w2, v2, fe2, b2, d2} !== at(q, c)) begin
                bad++; $display("FAIL rst_restart gap2 cycle %0d: got %b want %b", c, {w2, v2, fe2, b2, d2}, at(q, c));
            end
            if ({w0, v0, fe0, b0, d0} !== at(q, c)) begin
                bad++; $display("FAIL rst_restart gap0 cycle %0d: got %b want %b", c, {w0, v0, fe0, b0, d0}, at(q, c));
            end
            @(posedge Clock); #1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [3:0] pat, rep;
            int         j, m, mb, len2;
            pat  = 4'($urandom);
            rep  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            len2 = build(pat, int'(rep), 2).size();
            j    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len2 - 1)) : -1;
            mb   = (int'(rep) + 1) * 4;
            if (j >= 0 && j < mb) mb = j;
            m    = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, mb)) : -1;
            test_stream(pat, rep, j, m, "random");
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_repeat_gap();
        test_back_to_back();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
